// File: rtl/onchip_mem_pkg.sv
// rtl/onchip_mem_pkg.sv - shared types and constants for the on-chip memory arbiter
package onchip_mem_pkg;

  localparam int DEF_ADDR_W     = 13;
  localparam int DEF_DATA_W     = 256;
  localparam int DEF_RD_LATENCY = 2;
  localparam int DEF_MAX_BURST  = 16;

  // Requester identifiers carried in the read-return tags
  localparam logic REQ_C = 1'b0;
  localparam logic REQ_U = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_C = 2'd1,
    GNT_U = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  // Grant state that serves the given requester
  function automatic arb_state_t gnt_state(input logic id);
    return (id == REQ_U) ? GNT_U : GNT_C;
  endfunction

endpackage

// File: rtl/onchip_mem_arbiter_rd_tag_pipe.sv
// rtl/onchip_mem_arbiter_rd_tag_pipe.sv - fixed-depth shift register of read-return tags
module rd_tag_pipe
  import onchip_mem_pkg::*;
#(
  parameter int DEPTH = DEF_RD_LATENCY + 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t pipe [DEPTH];

  // Shift one tag per cycle; reset invalidates every in-flight read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - round-robin arbiter for the shared on-chip memory port
module onchip_mem_arbiter
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LATENCY = DEF_RD_LATENCY,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                mem_clk,
  input  logic                mem_rst_n,
  input  logic                c_req,
  input  logic                c_write,
  input  logic [ADDR_W-1:0]   c_addr,
  input  logic [DATA_W-1:0]   c_wdata,
  input  logic [DATA_W/8-1:0] c_be,
  output logic                c_gnt,
  output logic                c_rdata_valid,
  input  logic                u_req,
  input  logic                u_write,
  input  logic [ADDR_W-1:0]   u_addr,
  input  logic [DATA_W-1:0]   u_wdata,
  input  logic [DATA_W/8-1:0] u_be,
  output logic                u_gnt,
  output logic                u_rdata_valid,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_chip_select,
  output logic                mem_clk_ena,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_byte_enable,
  output logic [DATA_W-1:0]   mem_write_data,
  output logic                mem_write,
  input  logic [DATA_W-1:0]   mem_read_data
);

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  arb_state_t          state;
  logic                last;
  logic [7:0]          beat_cnt;

  logic                c_acc;
  logic                u_acc;
  logic                acc;
  logic                cur_id;
  logic                cur_req;
  logic                oth_req;
  logic                burst_done;

  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W/8-1:0] sel_be;
  logic [DATA_W-1:0]   sel_wdata;

  rd_tag_t             tag_in;
  rd_tag_t             tag_out;

  assign c_acc = c_req & c_gnt;
  assign u_acc = u_req & u_gnt;
  assign acc   = c_acc | u_acc;

  // In a grant state, "current" is the served requester and "other" the waiting one
  assign cur_id     = (state == GNT_U) ? REQ_U : REQ_C;
  assign cur_req    = (cur_id == REQ_U) ? u_req : c_req;
  assign oth_req    = (cur_id == REQ_U) ? c_req : u_req;
  assign burst_done = acc && (beat_cnt == BURST_LAST);

  // Arbitration state, beat counter, round-robin pointer and registered grants
  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      state    <= IDLE;
      last     <= REQ_U;
      beat_cnt <= '0;
      c_gnt    <= 1'b0;
      u_gnt    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (c_req && (!u_req || last == REQ_U)) begin
            state <= GNT_C;
            c_gnt <= 1'b1;
          end else if (u_req) begin
            state <= GNT_U;
            u_gnt <= 1'b1;
          end
        end
        default: begin
          if (!cur_req) begin
            // Served side went quiet: this cycle is the handover gap
            last     <= cur_id;
            beat_cnt <= '0;
            if (oth_req) begin
              state <= gnt_state(~cur_id);
              c_gnt <= (cur_id == REQ_U);
              u_gnt <= (cur_id == REQ_C);
            end else begin
              state <= IDLE;
              c_gnt <= 1'b0;
              u_gnt <= 1'b0;
            end
          end else if (burst_done && oth_req) begin
            // Burst expiry drops through IDLE, whose round-robin picks the other side
            last     <= cur_id;
            beat_cnt <= '0;
            state    <= IDLE;
            c_gnt    <= 1'b0;
            u_gnt    <= 1'b0;
          end else if (burst_done) begin
            beat_cnt <= '0;
          end else begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  // Select the command fields of whichever requester has a beat accepted
  always_comb begin
    sel_write = c_write;
    sel_addr  = c_addr;
    sel_be    = c_be;
    sel_wdata = c_wdata;
    if (u_acc) begin
      sel_write = u_write;
      sel_addr  = u_addr;
      sel_be    = u_be;
      sel_wdata = u_wdata;
    end
  end

  // Memory command register: strobes follow acceptance, address/data hold when idle
  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      mem_chip_select <= 1'b0;
      mem_write       <= 1'b0;
      mem_clk_ena     <= 1'b0;
      mem_addr        <= '0;
      mem_byte_enable <= '0;
      mem_write_data  <= '0;
    end else begin
      mem_clk_ena     <= 1'b1;
      mem_chip_select <= acc;
      mem_write       <= acc & sel_write;
      if (acc) begin
        mem_addr        <= sel_addr;
        mem_byte_enable <= sel_be;
        mem_write_data  <= sel_wdata;
      end
    end
  end

  assign tag_in.valid = acc & ~sel_write;
  assign tag_in.id    = u_acc ? REQ_U : REQ_C;

  // One stage per cycle from acceptance to read data, so the tag meets its data
  rd_tag_pipe #(
    .DEPTH (RD_LATENCY + 1)
  ) u_rd_tag_pipe (
    .clk     (mem_clk),
    .rst_n   (mem_rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign c_rdata_valid = tag_out.valid & (tag_out.id == REQ_C);
  assign u_rdata_valid = tag_out.valid & (tag_out.id == REQ_U);
  assign rdata         = mem_read_data;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb/tb_onchip_mem_arbiter.sv - self-checking bench for onchip_mem_arbiter
module tb_onchip_mem_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 256;
  localparam int BE_W   = DATA_W / 8;
  localparam int RDL    = 2;
  localparam int MAXB   = 16;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] PAT_AA = {32{8'hAA}};

  logic              mem_clk = 1'b0;
  logic              mem_rst_n = 1'b0;
  logic              c_req, c_write, u_req, u_write;
  logic [ADDR_W-1:0] c_addr, u_addr;
  logic [DATA_W-1:0] c_wdata, u_wdata;
  logic [BE_W-1:0]   c_be, u_be;
  logic              c_gnt, u_gnt, c_rdata_valid, u_rdata_valid;
  logic [DATA_W-1:0] rdata;
  logic              mem_chip_select, mem_clk_ena, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [BE_W-1:0]   mem_byte_enable;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data = '0;

  always #5 mem_clk = ~mem_clk;

  onchip_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RDL), .MAX_BURST(MAXB)
  ) dut (
    .mem_clk(mem_clk), .mem_rst_n(mem_rst_n),
    .c_req(c_req), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
    .c_gnt(c_gnt), .c_rdata_valid(c_rdata_valid),
    .u_req(u_req), .u_write(u_write), .u_addr(u_addr), .u_wdata(u_wdata), .u_be(u_be),
    .u_gnt(u_gnt), .u_rdata_valid(u_rdata_valid),
    .rdata(rdata), .mem_chip_select(mem_chip_select), .mem_clk_ena(mem_clk_ena),
    .mem_addr(mem_addr), .mem_byte_enable(mem_byte_enable), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, DATA_W'(act), DATA_W'(exp));
  endtask

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] o, input logic [DATA_W-1:0] n,
                                              input logic [BE_W-1:0] be);
    merge = o;
    for (int b = 0; b < BE_W; b++) if (be[b]) merge[b*8 +: 8] = n[b*8 +: 8];
  endfunction

  // Memory device: samples the command mid-cycle, returns read data RDL cycles later
  logic [DATA_W-1:0] dev_mem [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] dev_pipe [RDL];
  logic              cmd_rd, cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [BE_W-1:0]   cmd_be;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin dev_mem[i] = '0; ref_mem[i] = '0; end
    for (int i = 0; i < RDL; i++) dev_pipe[i] = '0;
    cmd_rd = 0; cmd_wr = 0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
  end

  always @(negedge mem_clk) begin
    cmd_rd = mem_chip_select & ~mem_write;
    cmd_wr = mem_chip_select & mem_write;
    cmd_addr = mem_addr; cmd_wdata = mem_write_data; cmd_be = mem_byte_enable;
  end

  always @(posedge mem_clk) begin
    for (int i = RDL - 1; i > 0; i--) dev_pipe[i] = dev_pipe[i-1];
    dev_pipe[0] = cmd_rd ? dev_mem[cmd_addr] : '0;
    if (cmd_wr) dev_mem[cmd_addr] = merge(dev_mem[cmd_addr], cmd_wdata, cmd_be);
    mem_read_data = dev_pipe[RDL-1];
  end

  // Behavioural model: who owns the port, the expected command, and reads due back
  typedef struct {
    int                due;
    logic              id;
    logic [DATA_W-1:0] data;
  } rd_exp_t;

  rd_exp_t           exp_q [$];
  rd_exp_t           m_new;
  int                cyc = 0;
  int                m_owner, m_beats, m_last, m_acc;
  logic              mine, other;
  logic              m_cs, m_wr, m_ena;
  logic [ADDR_W-1:0] m_addr;
  logic [BE_W-1:0]   m_be;
  logic [DATA_W-1:0] m_wdata;

  always @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      m_owner = 0; m_beats = 0; m_last = 2;
      m_cs = 0; m_wr = 0; m_ena = 0; m_addr = '0; m_be = '0; m_wdata = '0;
      exp_q.delete();
    end else begin
      m_acc = 0;
      if (m_owner == 1 && c_req) m_acc = 1;
      if (m_owner == 2 && u_req) m_acc = 2;
      if (m_acc != 0) begin
        m_cs    = 1;
        m_wr    = (m_acc == 1) ? c_write : u_write;
        m_addr  = (m_acc == 1) ? c_addr  : u_addr;
        m_be    = (m_acc == 1) ? c_be    : u_be;
        m_wdata = (m_acc == 1) ? c_wdata : u_wdata;
        if (m_wr) ref_mem[m_addr] = merge(ref_mem[m_addr], m_wdata, m_be);
        else begin
          m_new.due = cyc + 1 + RDL; m_new.id = (m_acc == 2); m_new.data = ref_mem[m_addr];
          exp_q.push_back(m_new);
        end
      end else begin
        m_cs = 0; m_wr = 0;
      end
      m_ena = 1;
      if (m_owner == 0) begin
        if (c_req && u_req) m_owner = (m_last == 1) ? 2 : 1;
        else if (c_req) m_owner = 1;
        else if (u_req) m_owner = 2;
      end else begin
        mine  = (m_owner == 1) ? c_req : u_req;
        other = (m_owner == 1) ? u_req : c_req;
        if (!mine) begin
          m_last = m_owner; m_owner = other ? 3 - m_owner : 0; m_beats = 0;
        end else begin
          m_beats++;
          if (m_beats == MAXB) begin
            m_beats = 0;
            if (other) begin m_last = m_owner; m_owner = 0; end
          end
        end
      end
      cyc++;
    end
  end

  // Compare process plus observation counters for the directed checks
  int                c_rv_cnt = 0, u_rv_cnt = 0, wr_cnt = 0;
  int                rv_id [$];
  int                rv_cyc [$];
  logic [DATA_W-1:0] u_last_rdata = '0;
  rd_exp_t           e;
  logic              ev_c, ev_u;

  always @(negedge mem_clk) begin
    if (mem_rst_n) begin
      ev_c = 0; ev_u = 0; e.data = '0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        ev_c = (e.id == 1'b0); ev_u = (e.id == 1'b1);
      end
      chk1("c_gnt", c_gnt, m_owner == 1);
      chk1("u_gnt", u_gnt, m_owner == 2);
      chk1("mem_chip_select", mem_chip_select, m_cs);
      chk1("mem_write", mem_write, m_wr);
      chk1("mem_clk_ena", mem_clk_ena, m_ena);
      chk("mem_addr", DATA_W'(mem_addr), DATA_W'(m_addr));
      chk("mem_byte_enable", DATA_W'(mem_byte_enable), DATA_W'(m_be));
      chk("mem_write_data", mem_write_data, m_wdata);
      chk1("c_rdata_valid", c_rdata_valid, ev_c);
      chk1("u_rdata_valid", u_rdata_valid, ev_u);
      if (ev_c || ev_u) chk("rdata", rdata, e.data);
      if (c_rdata_valid) begin c_rv_cnt++; rv_id.push_back(1); rv_cyc.push_back(cyc); end
      if (u_rdata_valid) begin u_rv_cnt++; rv_id.push_back(2); rv_cyc.push_back(cyc); u_last_rdata = rdata; end
      if (mem_write) wr_cnt++;
    end
  end

  task automatic clear_obs();
    @(posedge mem_clk);
    c_rv_cnt = 0; u_rv_cnt = 0; wr_cnt = 0; rv_id.delete(); rv_cyc.delete();
    @(negedge mem_clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk1({tag, "_c_gnt"}, c_gnt, 1'b0);
    chk1({tag, "_u_gnt"}, u_gnt, 1'b0);
    chk1({tag, "_cs"}, mem_chip_select, 1'b0);
    chk1({tag, "_wr"}, mem_write, 1'b0);
    chk1({tag, "_ena"}, mem_clk_ena, 1'b0);
    chk({tag, "_addr"}, DATA_W'(mem_addr), '0);
    chk({tag, "_be"}, DATA_W'(mem_byte_enable), '0);
    chk({tag, "_wdata"}, mem_write_data, '0);
    chk1({tag, "_c_rv"}, c_rdata_valid, 1'b0);
    chk1({tag, "_u_rv"}, u_rdata_valid, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge mem_clk); #2 mem_rst_n = 1'b0;
    repeat (2) @(posedge mem_clk);
    @(negedge mem_clk); #2 mem_rst_n = 1'b1;
    @(negedge mem_clk);
  endtask

  // Present one beat and return at the first negedge after it was accepted
  task automatic beat(input int who, input logic wr, input int ad, input logic [DATA_W-1:0] wd);
    int n;
    n = 0;
    if (who == 1) begin c_write = wr; c_addr = ADDR_W'(ad); c_wdata = wd; c_be = '1; c_req = 1; end
    else          begin u_write = wr; u_addr = ADDR_W'(ad); u_wdata = wd; u_be = '1; u_req = 1; end
    while (((who == 1) ? c_gnt : u_gnt) !== 1'b1 && n < 50) begin @(negedge mem_clk); n++; end
    chk1("beat_grant_wait", n < 50, 1'b1);
    @(negedge mem_clk);
  endtask

  int acc_log [$];
  int acc_cyc, n1, n2, n_beats, gaps, guard;

  initial begin
    c_req = 0; c_write = 0; c_addr = '0; c_wdata = '0; c_be = '0;
    u_req = 0; u_write = 0; u_addr = '0; u_wdata = '0; u_be = '0;
    repeat (3) @(posedge mem_clk);
    check_reset_vals("rst0");
    @(negedge mem_clk); #2 mem_rst_n = 1'b1;
    repeat (2) @(negedge mem_clk);

    // Single requester: C reads 0..3 back-to-back
    clear_obs();
    c_write = 0; c_be = '1; c_addr = '0; c_req = 1;
    chk1("t1_gnt_before", c_gnt, 1'b0);
    @(negedge mem_clk);
    chk1("t1_gnt_after", c_gnt, 1'b1);
    acc_cyc = cyc;
    for (int a = 0; a < 4; a++) begin c_addr = ADDR_W'(a); @(negedge mem_clk); end
    c_req = 0;
    repeat (8) @(negedge mem_clk);
    @(posedge mem_clk);
    chk("t1_c_rv_cnt", DATA_W'(c_rv_cnt), DATA_W'(4));
    chk("t1_u_rv_cnt", DATA_W'(u_rv_cnt), DATA_W'(0));
    chk("t1_first_rv_lat", DATA_W'(rv_cyc.size() > 0 ? rv_cyc[0] - acc_cyc : -1), DATA_W'(3));

    // Contention from reset: alternating 16-beat bursts with one gap cycle
    do_reset();
    clear_obs();
    c_write = 0; u_write = 0; c_req = 1; u_req = 1;
    for (int i = 0; i < 68; i++) begin
      c_addr = ADDR_W'(16 + i); u_addr = ADDR_W'(512 + i);
      acc_log.push_back((c_gnt && c_req) ? 1 : (u_gnt && u_req) ? 2 : 0);
      @(negedge mem_clk);
    end
    c_req = 0; u_req = 0;
    n1 = 0; n2 = 0;
    foreach (acc_log[i]) begin if (acc_log[i] == 1) n1++; if (acc_log[i] == 2) n2++; end
    chk("t2_c_beats", DATA_W'(n1), DATA_W'(32));
    chk("t2_u_beats", DATA_W'(n2), DATA_W'(32));
    chk("t2_beat16_c", DATA_W'(acc_log[16]), DATA_W'(1));
    chk("t2_gap17", DATA_W'(acc_log[17]), DATA_W'(0));
    chk("t2_beat18_u", DATA_W'(acc_log[18]), DATA_W'(2));
    chk("t2_gap34", DATA_W'(acc_log[34]), DATA_W'(0));
    repeat (8) @(negedge mem_clk);
    @(posedge mem_clk);
    chk("t2_c_rv_cnt", DATA_W'(c_rv_cnt), DATA_W'(32));
    chk("t2_u_rv_cnt", DATA_W'(u_rv_cnt), DATA_W'(32));
    @(negedge mem_clk);

    // Mixed traffic: C writes AA.. to 5, U reads it back
    clear_obs();
    beat(1, 1'b1, 5, PAT_AA);
    c_req = 0;
    beat(2, 1'b0, 5, '0);
    u_req = 0;
    repeat (8) @(negedge mem_clk);
    @(posedge mem_clk);
    chk("t3_write_cycles", DATA_W'(wr_cnt), DATA_W'(1));
    chk("t3_u_rv_cnt", DATA_W'(u_rv_cnt), DATA_W'(1));
    chk("t3_c_rv_cnt", DATA_W'(c_rv_cnt), DATA_W'(0));
    chk("t3_u_rdata", u_last_rdata, PAT_AA);
    @(negedge mem_clk);

    // In-flight reads survive a direct handover C -> U
    clear_obs();
    beat(1, 1'b0, 5, '0);
    beat(1, 1'b0, 6, '0);
    c_req = 0;
    beat(2, 1'b0, 7, '0);
    u_req = 0;
    repeat (8) @(negedge mem_clk);
    @(posedge mem_clk);
    chk("t4_rv_count", DATA_W'(rv_id.size()), DATA_W'(3));
    if (rv_id.size() == 3) begin
      chk("t4_rv0_id", DATA_W'(rv_id[0]), DATA_W'(1));
      chk("t4_rv1_id", DATA_W'(rv_id[1]), DATA_W'(1));
      chk("t4_rv2_id", DATA_W'(rv_id[2]), DATA_W'(2));
    end
    @(negedge mem_clk);

    // Reset one cycle after a read is accepted: the read never returns
    clear_obs();
    beat(1, 1'b0, 5, '0);
    c_req = 0;
    #2 mem_rst_n = 1'b0;
    repeat (2) @(posedge mem_clk);
    check_reset_vals("t5_rst");
    @(negedge mem_clk); #2 mem_rst_n = 1'b1;
    repeat (8) @(negedge mem_clk);
    @(posedge mem_clk);
    chk("t5_c_rv_cnt", DATA_W'(c_rv_cnt), DATA_W'(0));
    chk("t5_u_rv_cnt", DATA_W'(u_rv_cnt), DATA_W'(0));
    chk1("t5_ena", mem_clk_ena, 1'b1);
    @(negedge mem_clk);

    // Idle other requester: C keeps the grant across burst boundaries for 40 beats
    clear_obs();
    c_write = 0; c_req = 1; n_beats = 0; gaps = 0; guard = 0;
    while (n_beats < 40 && guard < 100) begin
      c_addr = ADDR_W'(1000 + n_beats);
      if (c_gnt) n_beats++;
      else if (n_beats > 0) gaps++;
      guard++;
      @(negedge mem_clk);
    end
    c_req = 0;
    chk("t6_beats", DATA_W'(n_beats), DATA_W'(40));
    chk("t6_gnt_drops", DATA_W'(gaps), DATA_W'(0));
    repeat (8) @(negedge mem_clk);
    @(posedge mem_clk);
    chk("t6_c_rv_cnt", DATA_W'(c_rv_cnt), DATA_W'(40));
    chk("t6_pending_reads", DATA_W'(exp_q.size()), DATA_W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
